// File: rtl/zapper_pkg.sv
// rtl/zapper_pkg.sv - shared types and defaults for the zapper input conditioner
package zapper_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } debounce_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 250000;
  localparam int LIGHT_THRESH_DEF    = 64;
  localparam int COUNT_W_DEF         = 19;
  localparam int COOLDOWN_FRAMES_DEF = 8;

  function automatic int db_cnt_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/zapper_input_cond_sync2.sv
// rtl/zapper_input_cond_sync2.sv - two-flop synchronizer with asynchronous reset
module sync2 (
  input  logic clk,
  input  logic screen_reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/zapper_input_cond.sv
// rtl/zapper_input_cond.sv - zapper trigger debounce and per-frame light detect
// Optional post-release cooldown lockout: define ZAPPER_COOLDOWN_EN.
module zapper_input_cond
  import zapper_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LIGHT_THRESH    = LIGHT_THRESH_DEF,
  parameter int COUNT_W         = COUNT_W_DEF,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               screen_reset,
  input  logic               frame_tick,
  input  logic               valid,
  input  logic               trigger_raw,
  input  logic               light_raw,
  output logic               trigger,
  output logic               detect,
  output logic [COUNT_W-1:0] light_level
);

  localparam int CNT_W = db_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic trg_s;
  logic light_s;

  sync2 u_sync_trg (
    .clk          (clk),
    .screen_reset (screen_reset),
    .d            (trigger_raw),
    .q            (trg_s)
  );

  sync2 u_sync_light (
    .clk          (clk),
    .screen_reset (screen_reset),
    .d            (light_raw),
    .q            (light_s)
  );

  debounce_state_t state, state_n;
  logic [CNT_W-1:0] db_cnt, db_cnt_n, db_cnt_inc;
  logic cd_busy;

  assign db_cnt_inc = db_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      state  <= RELEASED;
      db_cnt <= '0;
    end else begin
      state  <= state_n;
      db_cnt <= db_cnt_n;
    end
  end

  // The entry cycle into a WAIT state counts as the first stable cycle,
  // so the exit test looks at the incremented value.
  always_comb begin
    state_n  = state;
    db_cnt_n = db_cnt;
    case (state)
      RELEASED: begin
        if (trg_s && !cd_busy) begin
          state_n  = PRESS_WAIT;
          db_cnt_n = '0;
        end
      end
      PRESS_WAIT: begin
        if (!trg_s) begin
          state_n  = RELEASED;
          db_cnt_n = '0;
        end else if (db_cnt_inc == DB_LAST) begin
          state_n  = PRESSED;
          db_cnt_n = '0;
        end else begin
          db_cnt_n = db_cnt_inc;
        end
      end
      PRESSED: begin
        if (!trg_s) begin
          state_n  = RELEASE_WAIT;
          db_cnt_n = '0;
        end
      end
      RELEASE_WAIT: begin
        if (trg_s) begin
          state_n  = PRESSED;
          db_cnt_n = '0;
        end else if (db_cnt_inc == DB_LAST) begin
          state_n  = RELEASED;
          db_cnt_n = '0;
        end else begin
          db_cnt_n = db_cnt_inc;
        end
      end
      default: begin
        state_n  = RELEASED;
        db_cnt_n = '0;
      end
    endcase
  end

  assign trigger = (state == PRESSED) || (state == RELEASE_WAIT);

`ifdef ZAPPER_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  logic [CD_W-1:0] cd_cnt;

  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      cd_cnt <= '0;
    end else if (state_n == RELEASED && state != RELEASED) begin
      cd_cnt <= CD_W'(COOLDOWN_FRAMES);
    end else if (frame_tick && cd_cnt != '0) begin
      cd_cnt <= cd_cnt - CD_W'(1);
    end
  end

  assign cd_busy = (cd_cnt != '0);
`else
  logic cd_unused;
  assign cd_unused = (COOLDOWN_FRAMES != 0);
  assign cd_busy   = 1'b0;
`endif

  logic [COUNT_W-1:0] lit_cnt;
  logic               lit;

  assign lit = valid && light_s;

  // A lit pixel coincident with frame_tick belongs to the new frame.
  always_ff @(posedge clk or posedge screen_reset) begin
    if (screen_reset) begin
      lit_cnt     <= '0;
      light_level <= '0;
      detect      <= 1'b0;
    end else if (frame_tick) begin
      light_level <= lit_cnt;
      detect      <= (int'(lit_cnt) >= LIGHT_THRESH);
      lit_cnt     <= lit ? COUNT_W'(1) : '0;
    end else if (lit && lit_cnt != '1) begin
      lit_cnt <= lit_cnt + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_zapper_input_cond.sv
// tb/tb_zapper_input_cond.sv - directed self-checking bench for zapper_input_cond
module tb_zapper_input_cond;

  localparam int DB = 4;
  localparam int TH = 3;
  localparam int CW = 4;
  localparam int CD = 2;

  logic          clk = 1'b0;
  logic          screen_reset;
  logic          frame_tick;
  logic          valid;
  logic          trigger_raw;
  logic          light_raw;
  logic          trigger;
  logic          detect;
  logic [CW-1:0] light_level;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic lit;
    int   n_val;
    int   n_idle;
    int   exp_det;
    int   exp_lvl;
  } fvec_t;

  fvec_t vecs [7];

  always #5 clk = ~clk;

  zapper_input_cond #(
    .DEBOUNCE_CYCLES (DB),
    .LIGHT_THRESH    (TH),
    .COUNT_W         (CW),
    .COOLDOWN_FRAMES (CD)
  ) dut (
    .clk          (clk),
    .screen_reset (screen_reset),
    .frame_tick   (frame_tick),
    .valid        (valid),
    .trigger_raw  (trigger_raw),
    .light_raw    (light_raw),
    .trigger      (trigger),
    .detect       (detect),
    .light_level  (light_level)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called right after a raw edge is driven; trigger must change on the 6th edge.
  task automatic expect_edge(input string name, input int exp);
    step(DB + 1);
    chk({name, "_early"}, int'(trigger), 1 - exp);
    step(1);
    chk(name, int'(trigger), exp);
  endtask

  task automatic run_frame(input fvec_t v, input string name);
    light_raw = v.lit;
    valid     = 1'b0;
    step(3);
    valid = 1'b1;
    step(v.n_val);
    valid = 1'b0;
    step(v.n_idle);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk({name, "_detect"}, int'(detect), v.exp_det);
    chk({name, "_level"}, int'(light_level), v.exp_lvl);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2,  0, 0, 2};
    vecs[1] = '{1'b1, 4,  1, 1, 4};
    vecs[2] = '{1'b1, 0,  0, 0, 0};
    vecs[3] = '{1'b1, 20, 0, 1, 15};
    vecs[4] = '{1'b1, 3,  0, 1, 3};
    vecs[5] = '{1'b0, 6,  0, 0, 0};
    vecs[6] = '{1'b1, 15, 2, 1, 15};

    screen_reset = 1'b1;
    frame_tick   = 1'b0;
    valid        = 1'b0;
    trigger_raw  = 1'b0;
    light_raw    = 1'b0;
    step(2);
    chk("rst_trigger", int'(trigger), 0);
    chk("rst_detect", int'(detect), 0);
    chk("rst_level", int'(light_level), 0);
    screen_reset = 1'b0;
    step(2);

    trigger_raw = 1'b1;
    expect_edge("press", 1);
    step(3);
    trigger_raw = 1'b0;
    expect_edge("release", 0);
    step(3);

    trigger_raw = 1'b1;
    step(3);
    trigger_raw = 1'b0;
    step(2);
    chk("glitch_ignored", int'(trigger), 0);
    trigger_raw = 1'b1;
    expect_edge("glitch_then_press", 1);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], $sformatf("frame%0d", i));
    end

    light_raw = 1'b1;
    valid     = 1'b0;
    step(3);
    valid = 1'b1;
    step(2);
    frame_tick = 1'b1;
    step(1);
    chk("coincident_level", int'(light_level), 2);
    chk("coincident_detect", int'(detect), 0);
    valid = 1'b0;
    step(1);
    frame_tick = 1'b0;
    chk("back_to_back_level", int'(light_level), 1);
    step(2);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("empty_frame_level", int'(light_level), 0);

    run_frame('{1'b1, 3, 0, 1, 3}, "pre_reset");
    chk("pre_reset_trigger", int'(trigger), 1);
    #3 screen_reset = 1'b1;
    #1;
    chk("async_rst_trigger", int'(trigger), 0);
    chk("async_rst_detect", int'(detect), 0);
    chk("async_rst_level", int'(light_level), 0);
    step(1);
    screen_reset = 1'b0;
    expect_edge("post_reset_press", 1);

    step(2);
    trigger_raw = 1'b0;
    expect_edge("release2", 0);
`ifdef ZAPPER_COOLDOWN_EN
    trigger_raw = 1'b1;
    step(12);
    chk("cooldown_lock", int'(trigger), 0);
    trigger_raw = 1'b0;
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(2);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(2);
    trigger_raw = 1'b1;
    expect_edge("cooldown_expired_press", 1);
`else
    trigger_raw = 1'b1;
    expect_edge("immediate_repress", 1);
`endif

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/zapper_input_cond.md
Name: zapper_input_cond

Overview:
- Light-gun front end. Conditions the raw zapper trigger switch and photodiode.
- Sits directly upstream of the pattern generator and drives its trigger and detect inputs.
- trigger: debounced level, held while the gun is squeezed.
- detect: per-frame hit flag. Asserted for all of frame N+1 if frame N's active video showed at least LIGHT_THRESH lit pixel-clocks.

Parameters:
- DEBOUNCE_CYCLES, 250000, clocks raw trigger must be stable before trigger changes (about 10 ms at 25 MHz).
- LIGHT_THRESH, 64, minimum lit active-pixel count in one frame for detect.
- COUNT_W, 19, lit-pixel counter width (holds 640*480).
- COOLDOWN_FRAMES, 8, frames trigger is locked low after release (optional feature only).

Ports:
- clk  in  1  pixel clock.
- screen_reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-clk pulse at frame start, from the VGA timing block.
- valid  in  1  active-video qualifier, from the VGA timing block.
- trigger_raw  in  1  asynchronous gun switch, 1 = pressed.
- light_raw  in  1  asynchronous photodiode, 1 = light seen.
- trigger  out  1  debounced trigger level.
- detect  out  1  previous frame met the threshold.
- light_level  out  COUNT_W  lit count of the previous frame.

Behaviour:
- Reset: trigger=0, detect=0, light_level=0. Debounce FSM in RELEASED. All counters 0. Synchronizer flops 0.
- Reset is asynchronous and may arrive mid-operation. If trigger_raw is still held after reset, a full debounce is required before trigger asserts.
- Synchronizers: trigger_raw and light_raw each pass through 2 flops. Synced values are valid 2 clks after a raw edge.
- Debounce FSM, on synced trigger (trg_s):
  - RELEASED: trg_s=1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: counter increments while trg_s=1. trg_s=0 -> RELEASED, counter cleared. Counter reaching DEBOUNCE_CYCLES-1 with trg_s=1 -> PRESSED, trigger=1.
  - PRESSED: trg_s=0 -> RELEASE_WAIT.
  - RELEASE_WAIT: mirror of PRESS_WAIT. trg_s=1 -> back to PRESSED. Reaching the count with trg_s=0 -> RELEASED, trigger=0.
- Debounce latency: trigger changes exactly DEBOUNCE_CYCLES+2 clks after a clean raw edge.
- Light accumulation: lit_cnt increments on each clk with valid=1 and light_s=1. It saturates at 2^COUNT_W-1 with no wrap.
- On frame_tick:
  - light_level <= lit_cnt.
  - detect <= (lit_cnt >= LIGHT_THRESH).
  - lit_cnt <= (valid && light_s) ? 1 : 0, i.e. a coincident lit pixel counts toward the new frame.
- detect and light_level are stable between frame_ticks.
- frame_tick before any full frame after reset: evaluates whatever partial count exists. This is intended.
- Back-to-back frame_ticks: the second one publishes the count of the one intervening cycle.

Optional Feature:
- Macro: ZAPPER_COOLDOWN_EN.
- Defined:
  - On the transition to RELEASED, a frame counter loads COOLDOWN_FRAMES. It decrements on each frame_tick.
  - While it is nonzero, RELEASED ignores trg_s, so trigger cannot re-assert. This prevents fast rapid-fire.
  - Counter resets to 0.
- Undefined: no counter. RELEASED accepts a press immediately. COOLDOWN_FRAMES is unused.

Decomposition:
- zapper_pkg holds:
  - typedef enum debounce_state_t {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
  - Default constants: DEBOUNCE_CYCLES_DEF, LIGHT_THRESH_DEF, COUNT_W_DEF.
  - Debounce counter width function $clog2(DEBOUNCE_CYCLES).
- Sub-module sync2: two-flop synchronizer with async reset, instantiated twice.

Test Plan (bench uses DEBOUNCE_CYCLES=4, LIGHT_THRESH=3, COOLDOWN_FRAMES=2, COUNT_W=4):
- Reset, then trigger_raw high and held -> trigger rises exactly 6 clks later. trigger_raw low and held -> trigger falls 6 clks later.
- Glitch: trigger_raw high for 3 clks, low 2 clks, high and held -> no trigger on the glitch; trigger rises 6 clks after the final rising edge.
- 2 lit valid clks in frame, frame_tick -> detect=0, light_level=2. Then 5 lit clks (one with valid=0, not counted), frame_tick -> detect=1, light_level=4. Next frame 0 lit clks -> detect=0 after the following tick.
- 20 lit clks in one frame -> light_level=15 (saturated), detect=1.
- Lit pixel on the same clk as frame_tick -> published count excludes it; the next frame's count starts at 1.
- screen_reset pulsed while trigger=1 and detect=1 -> both 0 immediately (asynchronous). With trigger_raw still high, trigger re-asserts 6 clks after reset release.
- With ZAPPER_COOLDOWN_EN: press and release, then press again before 2 frame_ticks -> trigger stays 0. A press held after the 2nd tick asserts trigger 6 clks later.
